// File: rtl/obj_wbk_gen_if.sv
// Start/done handshake between the object sequencer and the writeback engine.
// The master raises start (with scaled); the slave reports done/busy/heightnz.
interface obj_wbk_gen_if;
   logic start;
   logic scaled;
   logic done;
   logic busy;
   logic heightnz;

   modport master (
      output start,
      output scaled,
      input  done,
      input  busy,
      input  heightnz
   );

   modport slave (
      input  start,
      input  scaled,
      output done,
      output busy,
      output heightnz
   );
endinterface

// File: rtl/obj_wbk_gen.sv
// Object-processor writeback engine: per-line height/data update with optional vertical scaling.
// Optional macro WBK_SKIPCNT_EN adds a skipcnt output counting Steps in the last operation.
module obj_wbk_gen #(
   parameter int DATA_W   = 21,
   parameter int HEIGHT_W = 10,
   parameter int DWIDTH_W = 10,
   parameter int REM_INT  = 3,
   parameter int REM_FRAC = 5
) (
   input  logic                         sys_clk,
   input  logic                         reset,
   obj_wbk_gen_if.slave                 ctl,
   input  logic [DWIDTH_W-1:0]          dwidth,
   input  logic [REM_INT+REM_FRAC-1:0]  vscale,
   input  logic                         ld_data,
   input  logic [DATA_W-1:0]            data_in,
   input  logic                         ld_height,
   input  logic [HEIGHT_W-1:0]          height_in,
   input  logic                         ld_rem,
   input  logic [REM_INT+REM_FRAC-1:0]  rem_in,
   output logic [DATA_W-1:0]            data,
   output logic [HEIGHT_W-1:0]          height,
   output logic [REM_INT+REM_FRAC-1:0]  rem,
`ifdef WBK_SKIPCNT_EN
   output logic [HEIGHT_W-1:0]          skipcnt,
`endif
   output logic [1:0]                   state_dbg
);

   localparam int RV_W  = REM_INT + REM_FRAC;
   localparam int REM_W = RV_W + 1;
   localparam logic [REM_W-1:0] ONE = REM_W'(1) << REM_FRAC;

   // Handshake: start is a request sampled only in S_IDLE; done is high exactly
   // while in S_IDLE, so the cycle done returns high the results are final.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_SCALE = 2'd2
   } state_t;

   state_t              state_q, state_nxt;
   logic                scaled_q, scaled_nxt;
   logic [DATA_W-1:0]   data_q, data_nxt;
   logic [HEIGHT_W-1:0] height_q, height_nxt;
   logic [REM_W-1:0]    rem_q, rem_nxt;
   logic                step;
   logic                clr_cnt;
   logic                lt1;

   // Remainder is below 1.0 when negative or when its integer field is zero.
   assign lt1 = rem_q[REM_W-1] | (rem_q[REM_W-2:REM_FRAC] == '0);

   always_comb begin
      state_nxt  = state_q;
      scaled_nxt = scaled_q;
      rem_nxt    = rem_q;
      step       = 1'b0;
      clr_cnt    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ctl.start) begin
               state_nxt  = S_CHECK;
               scaled_nxt = ctl.scaled;
               clr_cnt    = 1'b1;
            end
         end
         S_CHECK: begin
            if (!scaled_q) begin
               step      = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               rem_nxt   = rem_q - ONE;
               state_nxt = S_SCALE;
            end
         end
         S_SCALE: begin
            // Height exhaustion wins over the remainder test so the loop is bounded.
            if (height_q == '0) begin
               state_nxt = S_IDLE;
            end else if (lt1) begin
               rem_nxt = rem_q + REM_W'(vscale);
               step    = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Register loads take precedence over the arithmetic update of the same register.
   always_comb begin
      data_nxt   = step ? data_q + DATA_W'(dwidth) : data_q;
      height_nxt = step ? height_q - HEIGHT_W'(1) : height_q;
      if (ld_data)   data_nxt   = data_in;
      if (ld_height) height_nxt = height_in;
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         scaled_q <= 1'b0;
         data_q   <= '0;
         height_q <= '0;
         rem_q    <= '0;
      end else begin
         state_q  <= state_nxt;
         scaled_q <= scaled_nxt;
         data_q   <= data_nxt;
         height_q <= height_nxt;
         rem_q    <= ld_rem ? {1'b0, rem_in} : rem_nxt;
      end
   end

`ifdef WBK_SKIPCNT_EN
   logic [HEIGHT_W-1:0] skip_q;

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         skip_q <= '0;
      end else if (clr_cnt) begin
         skip_q <= '0;
      end else if (step && (skip_q != '1)) begin
         skip_q <= skip_q + HEIGHT_W'(1);
      end
   end

   assign skipcnt = skip_q;
`else
   logic unused_cnt;
   assign unused_cnt = clr_cnt;
`endif

   assign data         = data_q;
   assign height       = height_q;
   assign rem          = rem_q[RV_W-1:0];
   assign ctl.heightnz = (height_q != '0);
   assign ctl.done     = (state_q == S_IDLE);
   assign ctl.busy     = (state_q != S_IDLE);
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_obj_wbk_gen.sv
// Directed bench for obj_wbk_gen: vector table of single operations plus
// hand-written sequences for start-while-busy, mid-loop load and mid-loop reset.
module tb_obj_wbk_gen;

  logic        sys_clk;
  logic        reset;
  logic [9:0]  dwidth;
  logic [7:0]  vscale;
  logic        ld_data;
  logic [20:0] data_in;
  logic        ld_height;
  logic [9:0]  height_in;
  logic        ld_rem;
  logic [7:0]  rem_in;
  logic [20:0] data;
  logic [9:0]  height;
  logic [7:0]  rem;
  logic [1:0]  state_dbg;
`ifdef WBK_SKIPCNT_EN
  logic [9:0]  skipcnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  obj_wbk_gen_if wbk_if ();

  obj_wbk_gen dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .ctl       (wbk_if),
    .dwidth    (dwidth),
    .vscale    (vscale),
    .ld_data   (ld_data),
    .data_in   (data_in),
    .ld_height (ld_height),
    .height_in (height_in),
    .ld_rem    (ld_rem),
    .rem_in    (rem_in),
    .data      (data),
    .height    (height),
    .rem       (rem),
`ifdef WBK_SKIPCNT_EN
    .skipcnt   (skipcnt),
`endif
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [20:0] d;
    logic [9:0]  h;
    logic [7:0]  r;
    logic [9:0]  dw;
    logic [7:0]  vs;
    logic        sc;
    logic [20:0] exp_d;
    logic [9:0]  exp_h;
    logic [7:0]  exp_r;
    int          exp_cyc;
    int          exp_skip;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    wbk_if.start  = 1'b0;
    wbk_if.scaled = 1'b0;
    ld_data   = 1'b0;
    ld_height = 1'b0;
    ld_rem    = 1'b0;
  endtask

  // Loads and start in the same IDLE cycle; returns edges from start edge to done.
  task automatic launch(input vec_t v, output int cyc);
    data_in   = v.d;
    height_in = v.h;
    rem_in    = v.r;
    dwidth    = v.dw;
    vscale    = v.vs;
    ld_data   = 1'b1;
    ld_height = 1'b1;
    ld_rem    = 1'b1;
    wbk_if.start  = 1'b1;
    wbk_if.scaled = v.sc;
    @(posedge sys_clk); #1;
    idle_inputs();
    cyc = 1;
  endtask

  task automatic wait_done(inout int cyc);
    while (!wbk_if.done && cyc < 300) begin
      @(posedge sys_clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    vec_t v;

    //           d         h      r      dw      vs     sc  exp_d     exp_h  exp_r  cyc skip
    vecs[0] = '{21'h100,    10'd5,   8'h0A, 10'h20,  8'h00, 1'b0, 21'h120,    10'd4,   8'h0A, 2, 1};
    vecs[1] = '{21'h100,    10'd8,   8'h20, 10'h20,  8'h20, 1'b1, 21'h120,    10'd7,   8'h20, 4, 1};
    vecs[2] = '{21'h100,    10'd10,  8'h20, 10'h20,  8'h10, 1'b1, 21'h140,    10'd8,   8'h20, 5, 2};
    vecs[3] = '{21'h100,    10'd1,   8'h20, 10'h20,  8'h08, 1'b1, 21'h120,    10'd0,   8'h08, 4, 1};
    vecs[4] = '{21'h1FFFF0, 10'd3,   8'h00, 10'h20,  8'h00, 1'b0, 21'h000010, 10'd2,   8'h00, 2, 1};
    vecs[5] = '{21'h300,    10'd0,   8'h00, 10'h20,  8'h20, 1'b1, 21'h300,    10'd0,   8'hE0, 3, 0};
    vecs[6] = '{21'h000,    10'd4,   8'h30, 10'h10,  8'h18, 1'b1, 21'h010,    10'd3,   8'h28, 4, 1};
    vecs[7] = '{21'h050,    10'd3,   8'h00, 10'h10,  8'h00, 1'b1, 21'h080,    10'd0,   8'hE0, 6, 3};
    vecs[8] = '{21'h000,    10'd5,   8'h00, 10'h08,  8'h30, 1'b1, 21'h010,    10'd3,   8'h40, 5, 2};
    vecs[9] = '{21'h1000,   10'h3FF, 8'h7F, 10'h3FF, 8'h00, 1'b0, 21'h13FF,   10'h3FE, 8'h7F, 2, 1};

    idle_inputs();
    dwidth = '0; vscale = '0; data_in = '0; height_in = '0; rem_in = '0;
    reset = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_done", 32'(wbk_if.done), 32'd1);
    chk("rst_busy", 32'(wbk_if.busy), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_height", 32'(height), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_hnz", 32'(wbk_if.heightnz), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    @(posedge sys_clk); #1;

    // vector table
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i], cyc);
      chk($sformatf("v%0d_busy", i), 32'(wbk_if.busy), 32'd1);
      wait_done(cyc);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].exp_d));
      chk($sformatf("v%0d_height", i), 32'(height), 32'(vecs[i].exp_h));
      chk($sformatf("v%0d_rem", i), 32'(rem), 32'(vecs[i].exp_r));
      chk($sformatf("v%0d_hnz", i), 32'(wbk_if.heightnz), 32'(vecs[i].exp_h != 0));
`ifdef WBK_SKIPCNT_EN
      chk($sformatf("v%0d_skipcnt", i), 32'(skipcnt), 32'(vecs[i].exp_skip));
`endif
      @(posedge sys_clk); #1;
    end

    // start held high while busy must not queue a second operation
    v = '{21'h000, 10'd3, 8'h00, 10'h10, 8'h00, 1'b1, 21'h030, 10'd0, 8'hE0, 6, 3};
    launch(v, cyc);
    wbk_if.start  = 1'b1;
    wbk_if.scaled = 1'b1;
    repeat (2) begin
      @(posedge sys_clk); #1;
      cyc++;
    end
    wbk_if.start = 1'b0;
    wait_done(cyc);
    chk("busy_start_cycles", 32'(cyc), 32'd6);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("busy_start_done", 32'(wbk_if.done), 32'd1);
    chk("busy_start_data", 32'(data), 32'h030);
    chk("busy_start_height", 32'(height), 32'd0);
    chk("busy_start_rem", 32'(rem), 32'hE0);

    // height load during the skip loop overrides the decrement and ends the loop
    v = '{21'h000, 10'd100, 8'h00, 10'h40, 8'h00, 1'b1, 21'h0, 10'd0, 8'h0, 0, 0};
    launch(v, cyc);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("midload_h_before", 32'(height), 32'd98);
    height_in = 10'd0;
    ld_height = 1'b1;
    @(posedge sys_clk); #1;
    ld_height = 1'b0;
    chk("midload_height", 32'(height), 32'd0);
    chk("midload_busy", 32'(wbk_if.busy), 32'd1);
    @(posedge sys_clk); #1;
    chk("midload_done", 32'(wbk_if.done), 32'd1);
    chk("midload_data", 32'(data), 32'h0C0);
    chk("midload_rem", 32'(rem), 32'hE0);

    // synchronous reset in the middle of a long skip loop
    v = '{21'h040, 10'd100, 8'h00, 10'h10, 8'h00, 1'b1, 21'h0, 10'd0, 8'h0, 0, 0};
    launch(v, cyc);
    repeat (4) @(posedge sys_clk);
    #1;
    chk("midrst_busy", 32'(wbk_if.busy), 32'd1);
    chk("midrst_state", 32'(state_dbg), 32'd2);
    reset = 1'b1;
    @(posedge sys_clk); #1;
    reset = 1'b0;
    chk("midrst_done", 32'(wbk_if.done), 32'd1);
    chk("midrst_busy_lo", 32'(wbk_if.busy), 32'd0);
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_height", 32'(height), 32'd0);
    chk("midrst_rem", 32'(rem), 32'd0);
`ifdef WBK_SKIPCNT_EN
    chk("midrst_skipcnt", 32'(skipcnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
